// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - forwarding select encodings for the D stage (NONE/E/M/W) and E stage
//   - redirect FSM state type
//   - default exception entry vector and ERET excepttype code
package hazard_pkg;

    // D-stage operand mux: 00 regfile, 10 E, 01 M, 11 W
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_E    = 2'b10;
    localparam logic [1:0] FWD_M    = 2'b01;
    localparam logic [1:0] FWD_W    = 2'b11;

    // E-stage operand mux uses a different code map: 10 M, 01 W
    localparam logic [1:0] FWD_EX_M = 2'b10;
    localparam logic [1:0] FWD_EX_W = 2'b01;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
    localparam logic [31:0] ERET_CODE_DEF  = 32'h0000000E;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } redir_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority forwarding selector for one source operand.
//   src_i            source register field
//   weN_i / waddrN_i write enable and destination of write port N (port 0 highest)
//   sel_o            CODEn of the first matching port, FWD_NONE otherwise
// Register 0 never forwards. Tie we2_i low to use only two ports.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int         REG_AW = 5,
    parameter logic [1:0] CODE0  = FWD_E,
    parameter logic [1:0] CODE1  = FWD_M,
    parameter logic [1:0] CODE2  = FWD_W
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              we0_i,
    input  logic [REG_AW-1:0] waddr0_i,
    input  logic              we1_i,
    input  logic [REG_AW-1:0] waddr1_i,
    input  logic              we2_i,
    input  logic [REG_AW-1:0] waddr2_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_NONE;
        if (src_i != '0) begin
            if (we0_i && (waddr0_i == src_i)) begin
                sel_o = CODE0;
            end else if (we1_i && (waddr1_i == src_i)) begin
                sel_o = CODE1;
            end else if (we2_i && (waddr2_i == src_i)) begin
                sel_o = CODE2;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
//   Inputs : D/E register fields, E/M/W write flags, HI/LO and CP0 write flags,
//            divider busy, I/D SRAM wait, M-stage excepttype, current EPC.
//   Outputs: D/E forwarding selects, per-stage stall/flush, PC redirect with
//            target, fetch-discard, saturating stallF cycle counter.
//
// Redirect FSM:
//   state   | meaning
//   IDLE    | normal operation; an exception redirects the PC this cycle
//   HOLD    | exception taken during an outstanding fetch; keep redirecting to
//           | newpc_q and drop fetched data until the fetch completes
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int                REG_AW     = 5,
    parameter int                DATA_W     = 32,
    parameter int                LOAD_LAT   = 1,
    parameter logic [DATA_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [DATA_W-1:0] ERET_CODE  = ERET_CODE_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              hilo_writeM,
    input  logic              hilo_writeW,
    input  logic              cp0_writeM,
    input  logic              cp0_writeW,
    input  logic              stall_divE,
    input  logic              i_wait,
    input  logic              d_wait,
    input  logic [DATA_W-1:0] excepttypeM,
    input  logic [DATA_W-1:0] cp0_epc,
    output logic [1:0]        forwardaD,
    output logic [1:0]        forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic [1:0]        forwardHiLoE,
    output logic [1:0]        forwardCP0E,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] newpc,
    output logic              discard_if,
    output logic [31:0]       stall_cycles
);

    redir_state_e      state_q, state_d;
    logic [DATA_W-1:0] newpc_q, newpc_d;
    logic [31:0]       stall_cycles_q, stall_cycles_d;
    logic              exc_m;
    logic              lu;
    logic [DATA_W-1:0] exc_target;

    hazard_fwd_sel #(.REG_AW(REG_AW), .CODE0(FWD_E), .CODE1(FWD_M), .CODE2(FWD_W)) u_fwd_ad (
        .src_i(rsD), .we0_i(regwriteE), .waddr0_i(writeregE), .we1_i(regwriteM),
        .waddr1_i(writeregM), .we2_i(regwriteW), .waddr2_i(writeregW), .sel_o(forwardaD));

    hazard_fwd_sel #(.REG_AW(REG_AW), .CODE0(FWD_E), .CODE1(FWD_M), .CODE2(FWD_W)) u_fwd_bd (
        .src_i(rtD), .we0_i(regwriteE), .waddr0_i(writeregE), .we1_i(regwriteM),
        .waddr1_i(writeregM), .we2_i(regwriteW), .waddr2_i(writeregW), .sel_o(forwardbD));

    hazard_fwd_sel #(.REG_AW(REG_AW), .CODE0(FWD_EX_M), .CODE1(FWD_EX_W), .CODE2(FWD_NONE)) u_fwd_ae (
        .src_i(rsE), .we0_i(regwriteM), .waddr0_i(writeregM), .we1_i(regwriteW),
        .waddr1_i(writeregW), .we2_i(1'b0), .waddr2_i('0), .sel_o(forwardaE));

    hazard_fwd_sel #(.REG_AW(REG_AW), .CODE0(FWD_EX_M), .CODE1(FWD_EX_W), .CODE2(FWD_NONE)) u_fwd_be (
        .src_i(rtE), .we0_i(regwriteM), .waddr0_i(writeregM), .we1_i(regwriteW),
        .waddr1_i(writeregW), .we2_i(1'b0), .waddr2_i('0), .sel_o(forwardbE));

    always_comb begin
        forwardHiLoE = FWD_NONE;
        if (hilo_writeM) begin
            forwardHiLoE = FWD_EX_M;
        end else if (hilo_writeW) begin
            forwardHiLoE = FWD_EX_W;
        end
        forwardCP0E = FWD_NONE;
        if (cp0_writeM && (rdE == writeregM)) begin
            forwardCP0E = FWD_EX_M;
        end else if (cp0_writeW && (rdE == writeregW)) begin
            forwardCP0E = FWD_EX_W;
        end
    end

    // With LOAD_LAT=2 the load result is not ready until end of W, so a
    // load still sitting in M also blocks its D-stage consumer.
    always_comb begin
        lu = memtoregE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
        if (LOAD_LAT == 2) begin
            lu = lu || (memtoregM && (writeregM != '0) &&
                        ((writeregM == rsD) || (writeregM == rtD)));
        end
    end

    assign exc_m      = (excepttypeM != '0);
    assign exc_target = (excepttypeM == ERET_CODE) ? cp0_epc : EXC_VECTOR;

    // Exactly one row of the priority chain drives stall/flush each cycle.
    // HOLD outranks everything: M is already flushed and F is parked.
    always_comb begin
        state_d     = state_q;
        newpc_d     = newpc_q;
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        stallW      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushM      = 1'b0;
        flushW      = 1'b0;
        pc_redirect = 1'b0;
        discard_if  = 1'b0;
        newpc       = newpc_q;
        if (state_q == ST_HOLD) begin
            pc_redirect = 1'b1;
            discard_if  = 1'b1;
            stallF      = 1'b1;
            flushD      = 1'b1;
            if (!i_wait) begin
                state_d = ST_IDLE;
            end
        end else if (exc_m) begin
            flushD      = 1'b1;
            flushE      = 1'b1;
            flushM      = 1'b1;
            flushW      = 1'b1;
            pc_redirect = 1'b1;
            newpc       = exc_target;
            if (i_wait) begin
                // the in-flight fetch belongs to the squashed path
                discard_if = 1'b1;
                state_d    = ST_HOLD;
                newpc_d    = exc_target;
            end
        end else if (d_wait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (stall_divE) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lu) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (i_wait) begin
            stallF = 1'b1;
            flushD = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stallF && !pc_redirect && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            newpc_q        <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            newpc_q        <= newpc_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    typedef struct packed {
        logic        resetn;
        logic [4:0]  rsD, rtD, rsE, rtE, rdE, writeregE, writeregM, writeregW;
        logic        regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
        logic        hilo_writeM, hilo_writeW, cp0_writeM, cp0_writeW;
        logic        stall_divE, i_wait, d_wait;
        logic [31:0] excepttypeM, cp0_epc;
    } in_t;

    typedef struct packed {
        logic [1:0]  fad, fbd, fae, fbe, fhl, fcp;
        logic        sF, sD, sE, sM, sW, fD, fE, fM, fW, pcr;
        logic [31:0] newpc;
        logic        disc;
        logic [31:0] cnt;
    } out_t;

    typedef struct packed {
        logic        hold;
        logic [31:0] npc;
        logic [31:0] cnt;
    } mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t     cur = '0;
    mstate_t ms[2];
    out_t    q0[$];
    out_t    q1[$];
    int      checks = 0;
    int      errors = 0;
    bit      done = 1'b0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [1:0]  fad, fbd, fae, fbe, fhl, fcp;
        logic        sF, sD, sE, sM, sW, fD, fE, fM, fW, pcr, disc;
        logic [31:0] newpc, cnt;
        out_t        act;
        hazard_ctrl #(.LOAD_LAT(g + 1)) u_dut (
            .clk(clk), .resetn(cur.resetn),
            .rsD(cur.rsD), .rtD(cur.rtD), .rsE(cur.rsE), .rtE(cur.rtE), .rdE(cur.rdE),
            .writeregE(cur.writeregE), .writeregM(cur.writeregM), .writeregW(cur.writeregW),
            .regwriteE(cur.regwriteE), .regwriteM(cur.regwriteM), .regwriteW(cur.regwriteW),
            .memtoregE(cur.memtoregE), .memtoregM(cur.memtoregM),
            .hilo_writeM(cur.hilo_writeM), .hilo_writeW(cur.hilo_writeW),
            .cp0_writeM(cur.cp0_writeM), .cp0_writeW(cur.cp0_writeW),
            .stall_divE(cur.stall_divE), .i_wait(cur.i_wait), .d_wait(cur.d_wait),
            .excepttypeM(cur.excepttypeM), .cp0_epc(cur.cp0_epc),
            .forwardaD(fad), .forwardbD(fbd), .forwardaE(fae), .forwardbE(fbe),
            .forwardHiLoE(fhl), .forwardCP0E(fcp),
            .stallF(sF), .stallD(sD), .stallE(sE), .stallM(sM), .stallW(sW),
            .flushD(fD), .flushE(fE), .flushM(fM), .flushW(fW),
            .pc_redirect(pcr), .newpc(newpc), .discard_if(disc), .stall_cycles(cnt));
        assign act = {fad, fbd, fae, fbe, fhl, fcp, sF, sD, sE, sM, sW,
                      fD, fE, fM, fW, pcr, newpc, disc, cnt};
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_fwd_d(input logic [4:0] s, input in_t i);
        if (s == 5'd0) return 2'b00;
        if (i.regwriteE && i.writeregE == s) return 2'b10;
        if (i.regwriteM && i.writeregM == s) return 2'b01;
        if (i.regwriteW && i.writeregW == s) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [1:0] ref_fwd_e(input logic [4:0] s, input in_t i);
        if (s == 5'd0) return 2'b00;
        if (i.regwriteM && i.writeregM == s) return 2'b10;
        if (i.regwriteW && i.writeregW == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_target(input in_t i);
        return (i.excepttypeM == 32'h0000000E) ? i.cp0_epc : 32'hBFC00380;
    endfunction

    function automatic out_t ref_out(input in_t i, input mstate_t s, input int lat);
        out_t o;
        logic uses_e, uses_m;
        o = '0;
        o.fad = ref_fwd_d(i.rsD, i);
        o.fbd = ref_fwd_d(i.rtD, i);
        o.fae = ref_fwd_e(i.rsE, i);
        o.fbe = ref_fwd_e(i.rtE, i);
        o.fhl = i.hilo_writeM ? 2'b10 : (i.hilo_writeW ? 2'b01 : 2'b00);
        o.fcp = (i.cp0_writeM && i.rdE == i.writeregM) ? 2'b10 :
                ((i.cp0_writeW && i.rdE == i.writeregW) ? 2'b01 : 2'b00);
        uses_e = i.memtoregE && i.writeregE != 0 && (i.writeregE == i.rsD || i.writeregE == i.rtD);
        uses_m = i.memtoregM && i.writeregM != 0 && (i.writeregM == i.rsD || i.writeregM == i.rtD);
        o.newpc = s.npc;
        o.cnt   = s.cnt;
        if (s.hold) begin
            o.pcr = 1; o.disc = 1; o.sF = 1; o.fD = 1;
        end else if (i.excepttypeM != 0) begin
            {o.fD, o.fE, o.fM, o.fW, o.pcr} = 5'b11111;
            o.newpc = ref_target(i);
            o.disc  = i.i_wait;
        end else if (i.d_wait) begin
            {o.sF, o.sD, o.sE, o.sM, o.fW} = 5'b11111;
        end else if (i.stall_divE) begin
            {o.sF, o.sD, o.sE, o.fM} = 4'b1111;
        end else if (uses_e || (lat == 2 && uses_m)) begin
            {o.sF, o.sD, o.fE} = 3'b111;
        end else if (i.i_wait) begin
            {o.sF, o.fD} = 2'b11;
        end
        return o;
    endfunction

    function automatic mstate_t ref_step(input in_t i, input mstate_t s, input int lat);
        mstate_t n;
        out_t    o;
        n = s;
        o = ref_out(i, s, lat);
        if (!i.resetn) return '0;
        if (o.sF && !o.pcr && s.cnt != 32'hFFFF_FFFF) n.cnt = s.cnt + 1;
        if (s.hold) begin
            n.hold = i.i_wait;
        end else if (i.excepttypeM != 0 && i.i_wait) begin
            n.hold = 1;
            n.npc  = ref_target(i);
        end
        return n;
    endfunction

    // ---------------- stimulus ----------------
    task automatic apply(input in_t x);
        @(posedge clk);
        ms[0] = ref_step(cur, ms[0], 1);
        ms[1] = ref_step(cur, ms[1], 2);
        #1;
        cur = x;
        q0.push_back(ref_out(cur, ms[0], 1));
        q1.push_back(ref_out(cur, ms[1], 2));
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic cmp(input string t, input out_t a, input out_t e);
        check({t, ".forwardaD"}, 32'(a.fad), 32'(e.fad));
        check({t, ".forwardbD"}, 32'(a.fbd), 32'(e.fbd));
        check({t, ".forwardaE"}, 32'(a.fae), 32'(e.fae));
        check({t, ".forwardbE"}, 32'(a.fbe), 32'(e.fbe));
        check({t, ".forwardHiLoE"}, 32'(a.fhl), 32'(e.fhl));
        check({t, ".forwardCP0E"}, 32'(a.fcp), 32'(e.fcp));
        check({t, ".stalls"}, 32'({a.sF, a.sD, a.sE, a.sM, a.sW}), 32'({e.sF, e.sD, e.sE, e.sM, e.sW}));
        check({t, ".flushes"}, 32'({a.fD, a.fE, a.fM, a.fW}), 32'({e.fD, e.fE, e.fM, e.fW}));
        check({t, ".pc_redirect"}, 32'(a.pcr), 32'(e.pcr));
        check({t, ".newpc"}, a.newpc, e.newpc);
        check({t, ".discard_if"}, 32'(a.disc), 32'(e.disc));
        check({t, ".stall_cycles"}, a.cnt, e.cnt);
    endtask

    initial begin
        out_t e;
        while (!done) begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp("lat1", g_dut[0].act, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp("lat2", g_dut[1].act, e);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        in_t b, x;
        ms[0] = '0;
        ms[1] = '0;
        b = '0;
        b.resetn = 1'b1;

        // bring the DUTs into a known state before the first check
        @(posedge clk);
        @(posedge clk);
        cur.resetn = 1'b1;
        q0.delete();
        q1.delete();
        x = b; x.resetn = 0; apply(x); apply(x);
        apply(b); apply(b);

        // E-stage forwarding priority and register 0
        x = b; x.rsE = 3; x.writeregM = 3; x.writeregW = 3; x.regwriteM = 1; x.regwriteW = 1;
        apply(x);
        x.regwriteM = 0; apply(x);
        x.rsE = 0;       apply(x);
        // D-stage priority E > M > W
        x = b; x.rsD = 7; x.rtD = 7; x.writeregE = 7; x.writeregM = 7; x.writeregW = 7;
        x.regwriteE = 1; x.regwriteM = 1; x.regwriteW = 1;
        apply(x);
        x.regwriteE = 0; apply(x);
        x.regwriteM = 0; apply(x);

        // load-use in E, then the load in M (only LOAD_LAT=2 stalls)
        x = b; x.memtoregE = 1; x.writeregE = 5; x.rtD = 5; apply(x);
        x = b; x.memtoregM = 1; x.writeregM = 5; x.rtD = 5; apply(x);
        x = b; x.memtoregE = 1; x.writeregE = 0; x.rsD = 0; apply(x);

        // d_wait dominates divider stall; counter advances each cycle
        x = b; x.d_wait = 1; x.stall_divE = 1;
        apply(x); apply(x); apply(x);
        apply(b);

        // exception with no pending fetch, then ERET to EPC
        x = b; x.excepttypeM = 32'h4; apply(x);
        x = b; x.excepttypeM = 32'hE; x.cp0_epc = 32'h80001234; apply(x);
        apply(b);

        // exception during a 3-cycle fetch wait, then let it complete
        x = b; x.excepttypeM = 32'h4; x.i_wait = 1; apply(x);
        x = b; x.i_wait = 1; x.excepttypeM = 32'h20; apply(x);
        x = b; x.i_wait = 1; apply(x);
        apply(b); apply(b);

        // reset in the middle of HOLD
        x = b; x.excepttypeM = 32'hE; x.cp0_epc = 32'h8000_0ABC; x.i_wait = 1; apply(x);
        x = b; x.i_wait = 1; apply(x);
        x.resetn = 0; apply(x);
        apply(b); apply(b);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            x = b;
            x.resetn      = ($urandom_range(0, 199) != 0);
            x.rsD         = 5'($urandom_range(0, 3));
            x.rtD         = 5'($urandom_range(0, 3));
            x.rsE         = 5'($urandom_range(0, 3));
            x.rtE         = 5'($urandom_range(0, 3));
            x.rdE         = 5'($urandom_range(1, 3));
            x.writeregE   = 5'($urandom_range(0, 3));
            x.writeregM   = 5'($urandom_range(0, 3));
            x.writeregW   = 5'($urandom_range(0, 3));
            x.regwriteE   = 1'($urandom_range(0, 1));
            x.regwriteM   = 1'($urandom_range(0, 1));
            x.regwriteW   = 1'($urandom_range(0, 1));
            x.memtoregE   = 1'($urandom_range(0, 1));
            x.memtoregM   = 1'($urandom_range(0, 1));
            x.hilo_writeM = 1'($urandom_range(0, 1));
            x.hilo_writeW = 1'($urandom_range(0, 1));
            x.cp0_writeM  = 1'($urandom_range(0, 1));
            x.cp0_writeW  = 1'($urandom_range(0, 1));
            x.stall_divE  = ($urandom_range(0, 7) == 0);
            x.d_wait      = ($urandom_range(0, 7) == 0);
            x.i_wait      = ($urandom_range(0, 2) == 0);
            x.cp0_epc     = $urandom;
            case ($urandom_range(0, 15))
                0: x.excepttypeM = 32'hE;
                1: x.excepttypeM = 32'h4;
                2: x.excepttypeM = 32'($urandom_range(1, 255));
                default: x.excepttypeM = 32'h0;
            endcase
            apply(x);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        done = 1'b1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain act=%0d exp=0", q0.size() + q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
